// File: rtl/sync_fifo_lvl.sv
// ============================================================================
// sync_fifo_lvl : single-clock FIFO with registered/FWFT read, fill level and
//                 almost-full/almost-empty flags; sticky ovf/udf under FIFO_ERR_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_lvl #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 16,
  parameter  int FWFT       = 0,
  parameter  int AFULL_TH   = DEPTH - 2,
  parameter  int AEMPTY_TH  = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  rinc,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  rvalid,
  output logic [WIDTH-1:0]      rdata
`ifdef FIFO_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  ovf,
  output logic                  udf
`endif
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  wen, ren;

  assign waddr  = wptr_q[ADDR_WIDTH-1:0];
  assign raddr  = rptr_q[ADDR_WIDTH-1:0];
  assign count  = wptr_q - rptr_q;
  assign rempty = (count == '0);
  assign wfull  = (waddr == raddr) && (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
  assign afull  = (count >= AFULL_LVL);
  assign aempty = (count <= AEMPTY_LVL);

  assign wen = winc & ~wfull;
  assign ren = rinc & ~rempty;

  always_comb begin
    wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, wen};
    rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, ren};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (!rst && wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata  = mem_q[raddr];
      assign rvalid = ~rempty;
    end else begin : g_reg_read
      logic             rvalid_q, rvalid_d;
      logic [WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rvalid_d = ren;
        rdata_d  = rdata_q;
        if (ren) begin
          rdata_d = mem_q[raddr];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= rvalid_d;
          rdata_q  <= rdata_d;
        end
      end

      assign rvalid = rvalid_q;
      assign rdata  = rdata_q;
    end
  endgenerate

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (winc && wfull) begin
      ovf_d = 1'b1;
    end
    if (rinc && rempty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
// ============================================================================
// tb_sync_fifo_lvl : scoreboard bench for sync_fifo_lvl (registered and FWFT)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, winc, rinc, err_clr;
  logic [WIDTH-1:0] wdata;
  logic             wfull, rempty, afull, aempty, rvalid;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rdata;

  logic             winc2, rinc2;
  logic [WIDTH-1:0] wdata2;
  logic             wfull2, rempty2, afull2, aempty2, rvalid2;
  logic [AW:0]      count2;
  logic [WIDTH-1:0] rdata2;

`ifdef FIFO_ERR_EN
  logic ovf, udf, ovf2, udf2;
`endif

  sync_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .wfull(wfull), .rempty(rempty), .afull(afull), .aempty(aempty),
    .count(count), .rvalid(rvalid), .rdata(rdata)
`ifdef FIFO_ERR_EN
    , .err_clr(err_clr), .ovf(ovf), .udf(udf)
`endif
  );

  sync_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .winc(winc2), .wdata(wdata2), .rinc(rinc2),
    .wfull(wfull2), .rempty(rempty2), .afull(afull2), .aempty(aempty2),
    .count(count2), .rvalid(rvalid2), .rdata(rdata2)
`ifdef FIFO_ERR_EN
    , .err_clr(err_clr), .ovf(ovf2), .udf(udf2)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model for the registered-read instance
  logic [WIDTH-1:0] sb_q[$];
  int               m_cnt;
  logic             m_rv;
  logic [WIDTH-1:0] m_rd;
  logic             m_ovf, m_udf;

  // Reference model for the FWFT instance
  logic [WIDTH-1:0] sb2_q[$];

  task automatic check_flags();
    chk("count",  32'(count),  32'(m_cnt));
    chk("wfull",  32'(wfull),  32'(m_cnt == DEPTH));
    chk("rempty", 32'(rempty), 32'(m_cnt == 0));
    chk("afull",  32'(afull),  32'(m_cnt >= DEPTH - 2));
    chk("aempty", 32'(aempty), 32'(m_cnt <= 2));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    chk("rdata",  32'(rdata),  32'(m_rd));
`ifdef FIFO_ERR_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic ec);
    logic acc_w, acc_r;
    winc = w; wdata = d; rinc = r; err_clr = ec;
    @(posedge clk);
    acc_r = r && (m_cnt > 0);
    acc_w = w && (m_cnt < DEPTH);
    if (ec) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && m_cnt == DEPTH) m_ovf = 1'b1;
    if (r && m_cnt == 0)     m_udf = 1'b1;
    m_rv = acc_r;
    if (acc_r) m_rd = sb_q.pop_front();
    if (acc_w) sb_q.push_back(d);
    m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    check_flags();
  endtask

  task automatic step2(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic acc_r;
    winc2 = w; wdata2 = d; rinc2 = r;
    @(posedge clk);
    acc_r = r && (sb2_q.size() > 0);
    if (acc_r) void'(sb2_q.pop_front());
    if (w && sb2_q.size() < DEPTH) sb2_q.push_back(d);
    #1;
    winc2 = 1'b0; rinc2 = 1'b0;
    chk("fwft_count",  32'(count2),  32'(sb2_q.size()));
    chk("fwft_rempty", 32'(rempty2), 32'(sb2_q.size() == 0));
    chk("fwft_rvalid", 32'(rvalid2), 32'(sb2_q.size() != 0));
    if (sb2_q.size() != 0) chk("fwft_rdata", 32'(rdata2), 32'(sb2_q[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    winc = 1'b1; wdata = 8'hEE; rinc = 1'b1;
    winc2 = 1'b1; wdata2 = 8'hEE; rinc2 = 1'b1;
    @(posedge clk);
    sb_q.delete(); sb2_q.delete();
    m_cnt = 0; m_rv = 1'b0; m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    rst = 1'b0;
    winc = 1'b0; rinc = 1'b0; winc2 = 1'b0; rinc2 = 1'b0;
    check_flags();
    chk("fwft_rst_count",  32'(count2),  32'd0);
    chk("fwft_rst_rvalid", 32'(rvalid2), 32'd0);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
    winc2 = 1'b0; rinc2 = 1'b0; wdata2 = '0;
    do_reset();

    // Fill completely, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Simultaneous access while full: write dropped, overflow flagged
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Read while empty, then clear racing a new underflow
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Steady-state streaming across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous access while empty: write only
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset with data in flight and a pending read
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // First-word-fall-through instance
    step2(1'b0, '0, 1'b0);
    step2(1'b1, 8'h5A, 1'b0);
    step2(1'b0, '0, 1'b1);
    step2(1'b1, 8'h11, 1'b0);
    step2(1'b1, 8'h22, 1'b0);
    step2(1'b1, 8'h33, 1'b1);
    step2(1'b0, '0, 1'b1);
    step2(1'b0, '0, 1'b1);
    step2(1'b0, '0, 1'b0);
`ifdef FIFO_ERR_EN
    chk("fwft_ovf", 32'(ovf2), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
